// File: rtl/decode_issue.sv
// decode_issue: decode and issue stage feeding the ALU.
// Splits instruction words, reads operands from a 32x32 register file,
// tracks in-flight destinations in a scoreboard and holds each decoded
// operation until the ALU side accepts it.
// Optional feature: define DECODE_ISSUE_BYPASS_EN to let a same-cycle
// writeback satisfy a pending operand (value forwarded from wb_data).
module decode_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic [15:0] ex_imm,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [4:0]  ex_rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        illegal
);

  // Architectural state
  logic [31:0] r_rf [1:31];
  logic [31:1] r_pending;

  // Output holding register
  logic        r_ex_valid;
  logic [5:0]  r_ex_opcode;
  logic [5:0]  r_ex_funct;
  logic [15:0] r_ex_imm;
  logic [31:0] r_ex_a;
  logic [31:0] r_ex_b;
  logic [4:0]  r_ex_rd;
  logic        r_illegal;

  // Decode fields
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_dest;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_legal;

  // Register file view with r0 hard-wired to zero, writeback decode
  logic [31:0] w_rf [0:31];
  logic [31:0] w_wb_dec;
  logic [31:0] w_pend;
  logic [31:0] w_pend_eff;
  logic [31:0] w_a;
  logic [31:0] w_b_raw;
  logic [31:0] w_b;
  logic        w_hazard;
  logic        w_xfer;
  logic        w_issue;

  assign w_opcode = if_instr[31:26];
  assign w_rs     = if_instr[25:21];
  assign w_rt     = if_instr[20:16];
  assign w_is_r   = (w_opcode == 6'd0);
  assign w_is_i   = (w_opcode >= 6'd1) && (w_opcode <= 6'd6);
  assign w_legal  = w_is_r || w_is_i;
  assign w_dest   = w_is_r ? if_instr[15:11] : if_instr[20:16];

  assign w_rf[0]     = '0;
  assign w_wb_dec[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      assign w_rf[gi]     = r_rf[gi];
      assign w_wb_dec[gi] = wb_en && (wb_addr == 5'(gi));
    end
  endgenerate

  // r0 is never pending
  assign w_pend = {r_pending, 1'b0};

`ifdef DECODE_ISSUE_BYPASS_EN
  // A writeback landing this cycle resolves the dependency and supplies the operand
  assign w_pend_eff = w_pend & ~w_wb_dec;
  assign w_a        = w_wb_dec[w_rs] ? wb_data : w_rf[w_rs];
  assign w_b_raw    = w_wb_dec[w_rt] ? wb_data : w_rf[w_rt];
`else
  // Pending bit holds until the writeback edge; the file is read afterwards
  assign w_pend_eff = w_pend;
  assign w_a        = w_rf[w_rs];
  assign w_b_raw    = w_rf[w_rt];
`endif

  assign w_b = w_is_r ? w_b_raw : '0;

  // Illegal opcodes read nothing and write nothing, so they never stall on hazards
  assign w_hazard = w_legal && (w_pend_eff[w_rs] ||
                                (w_is_r && w_pend_eff[w_rt]) ||
                                w_pend_eff[w_dest]);

  assign if_ready = rst_n && !w_hazard && (!r_ex_valid || ex_ready);
  assign w_xfer   = if_valid && if_ready;
  assign w_issue  = w_xfer && w_legal;

  // Register file: writeback strobe updates r1..r31
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) r_rf[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_wb_dec[i]) r_rf[i] <= wb_data;
      end
    end
  end

  // Scoreboard: set on issue of a destination, clear on writeback, set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_issue && (w_dest == 5'(i))) r_pending[i] <= 1'b1;
        else if (w_wb_dec[i])             r_pending[i] <= 1'b0;
      end
    end
  end

  // Output register: load on issue, hold while stalled, drop valid once consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_opcode <= '0;
      r_ex_funct  <= '0;
      r_ex_imm    <= '0;
      r_ex_a      <= '0;
      r_ex_b      <= '0;
      r_ex_rd     <= '0;
      r_illegal   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_ex_valid  <= 1'b1;
        r_ex_opcode <= w_opcode;
        r_ex_funct  <= w_is_r ? if_instr[5:0] : 6'd0;
        r_ex_imm    <= if_instr[15:0];
        r_ex_a      <= w_a;
        r_ex_b      <= w_b;
        r_ex_rd     <= w_dest;
      end else if (ex_ready) begin
        r_ex_valid  <= 1'b0;
      end
      r_illegal <= w_xfer && !w_legal;
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_opcode = r_ex_opcode;
  assign ex_funct  = r_ex_funct;
  assign ex_imm    = r_ex_imm;
  assign ex_a      = r_ex_a;
  assign ex_b      = r_ex_b;
  assign ex_rd     = r_ex_rd;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed bench for decode_issue with an expected-operation queue.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic        if_ready;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic [15:0] ex_imm;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_rd;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        illegal;

  decode_issue dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_imm(ex_imm),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected operation derived from the instruction fields plus the operand values
  task automatic push(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.op  = instr[31:26];
    e.fn  = (instr[31:26] == 6'd0) ? instr[5:0] : 6'd0;
    e.imm = instr[15:0];
    e.a   = a;
    e.b   = b;
    e.rd  = (instr[31:26] == 6'd0) ? instr[15:11] : instr[20:16];
    sb_q.push_back(e);
  endtask

  task automatic check_ex();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("ex_valid", 32'(ex_valid), 32'd1);
      chk("ex_opcode", 32'(ex_opcode), 32'(e.op));
      chk("ex_funct", 32'(ex_funct), 32'(e.fn));
      chk("ex_imm", 32'(ex_imm), 32'(e.imm));
      chk("ex_a", ex_a, e.a);
      chk("ex_b", ex_b, e.b);
      chk("ex_rd", 32'(ex_rd), 32'(e.rd));
      $display("op=%h fn=%h imm=%h a=%h b=%h rd=%0d", ex_opcode, ex_funct, ex_imm, ex_a, ex_b, ex_rd);
      last_exp = e;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_ex_a", ex_a, 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    rst_n = 1'b1;

    // Preload r3 and r2 through the writeback port
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd5;
    step();
    wb_addr = 5'd2; wb_data = 32'hCAFE_0002;
    step();
    wb_en = 1'b0;

    // R-type rs=3 rt=0 rd=7 funct=1
    if_instr = mk_r(5'd3, 5'd0, 5'd7, 6'd1); if_valid = 1'b1; ex_ready = 1'b0;
    #1 chk("ready_rtype", 32'(if_ready), 32'd1);
    push(if_instr, 32'd5, 32'd0);
    step();
    if_valid = 1'b0;
    check_ex();

    // Read-after-write on r7
    if_instr = mk_i(6'd2, 5'd7, 5'd8, 16'h1234); if_valid = 1'b1; ex_ready = 1'b1;
    #1 chk("raw_stall0", 32'(if_ready), 32'd0);
    step();
    chk("drained", 32'(ex_valid), 32'd0);
    #1 chk("raw_stall1", 32'(if_ready), 32'd0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd9;
    #1;
`ifdef DECODE_ISSUE_BYPASS_EN
    chk("bypass_ready", 32'(if_ready), 32'd1);
    push(if_instr, 32'd9, 32'd0);
    step();
    wb_en = 1'b0;
`else
    chk("wb_cycle_stall", 32'(if_ready), 32'd0);
    step();
    wb_en = 1'b0;
    #1 chk("post_wb_ready", 32'(if_ready), 32'd1);
    push(if_instr, 32'd9, 32'd0);
    step();
`endif
    if_valid = 1'b0;
    check_ex();

    // I-type: funct forced to 0, rt is the destination, ex_b is 0
    if_instr = mk_i(6'd1, 5'd2, 5'd4, 16'h00FF); if_valid = 1'b1;
    #1 chk("ready_itype", 32'(if_ready), 32'd1);
    push(if_instr, 32'hCAFE_0002, 32'd0);
    step();
    check_ex();

    // Backpressure: ALU not ready for three cycles, outputs hold
    ex_ready = 1'b0;
    if_instr = mk_r(5'd3, 5'd2, 5'd10, 6'd5);
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_if_ready", 32'(if_ready), 32'd0);
      chk("hold_valid", 32'(ex_valid), 32'd1);
      chk("hold_a", ex_a, last_exp.a);
      chk("hold_imm", 32'(ex_imm), 32'(last_exp.imm));
      chk("hold_rd", 32'(ex_rd), 32'(last_exp.rd));
      step();
    end
    ex_ready = 1'b1;
    #1 chk("release_ready", 32'(if_ready), 32'd1);
    push(if_instr, 32'd5, 32'hCAFE_0002);
    step();
    check_ex();

    // Drain, then an illegal opcode alongside a writeback to non-pending r20
    if_valid = 1'b0;
    step();
    chk("drain2", 32'(ex_valid), 32'd0);
    if_instr = mk_i(6'd9, 5'd1, 5'd12, 16'h0000); if_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'd77;
    #1 chk("ready_illegal", 32'(if_ready), 32'd1);
    step();
    if_valid = 1'b0; wb_en = 1'b0;
    chk("illegal_pulse", 32'(illegal), 32'd1);
    chk("illegal_no_issue", 32'(ex_valid), 32'd0);
    step();
    chk("illegal_one_cycle", 32'(illegal), 32'd0);

    // r12 must not have been marked pending by the illegal instruction
    if_instr = mk_i(6'd3, 5'd0, 5'd12, 16'h0042); if_valid = 1'b1;
    #1 chk("illegal_no_pend", 32'(if_ready), 32'd1);
    push(if_instr, 32'd0, 32'd0);
    step();
    check_ex();

    // Write-after-write on r12 and R-type rt hazard on r4
    if_instr = mk_r(5'd0, 5'd0, 5'd12, 6'd0);
    #1 chk("waw_stall", 32'(if_ready), 32'd0);
    if_instr = mk_r(5'd0, 5'd4, 5'd13, 6'd0);
    #1 chk("rt_stall", 32'(if_ready), 32'd0);

    // Read r20 (written while not pending), destination r5
    if_instr = mk_r(5'd20, 5'd0, 5'd5, 6'd2);
    #1 chk("ready_r20", 32'(if_ready), 32'd1);
    push(if_instr, 32'd77, 32'd0);
    step();
    ex_ready = 1'b0; if_valid = 1'b0;
    check_ex();

    // Asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'd0);
    chk("async_rst_a", ex_a, 32'd0);
    chk("async_rst_ready", 32'(if_ready), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    if_instr = mk_r(5'd5, 5'd3, 5'd6, 6'd3); if_valid = 1'b1; ex_ready = 1'b1;
    #1 chk("rst_cleared_pend", 32'(if_ready), 32'd1);
    push(if_instr, 32'd0, 32'd0);
    step();
    check_ex();

    // Back-to-back issue
    if_instr = mk_i(6'd5, 5'd0, 5'd20, 16'h0001);
    #1 chk("b2b_ready0", 32'(if_ready), 32'd1);
    push(if_instr, 32'd0, 32'd0);
    step();
    check_ex();
    if_instr = mk_i(6'd6, 5'd0, 5'd21, 16'h0002);
    #1 chk("b2b_ready1", 32'(if_ready), 32'd1);
    push(if_instr, 32'd0, 32'd0);
    step();
    check_ex();

    // Writes to r0 are ignored
    if_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    step();
    wb_en = 1'b0;
    if_instr = mk_r(5'd0, 5'd0, 5'd9, 6'd0); if_valid = 1'b1;
    #1 chk("ready_r0", 32'(if_ready), 32'd1);
    push(if_instr, 32'd0, 32'd0);
    step();
    if_valid = 1'b0;
    check_ex();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
